// File: rtl/modbus_rtu_slave_rx_pkg.sv
// Shared constants, frame FSM state encodings and the CRC-16/MODBUS byte fold.
package modbus_rtu_slave_rx_pkg;

    localparam logic [7:0]  FC_READ_HOLD   = 8'h03;
    localparam logic [7:0]  FC_WRITE_MULTI = 8'h10;
    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC_POLY       = 16'hA001;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRecv  = 3'd1;
    localparam logic [2:0] StCheck = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StPulse = 3'd4;

    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_rtu_slave_rx_uart_byte_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, byte-done pulse with framing flag.
module modbus_rtu_slave_rx_uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       line_o,
    output logic [7:0] byte_o,
    output logic       done_o,
    output logic       err_o
);
    localparam int unsigned BitCyc = CLK_FREQ / BAUD;
    localparam int unsigned CntW   = $clog2(BitCyc);
    localparam logic [CntW-1:0] BitMax  = CntW'(BitCyc - 1);
    localparam logic [CntW-1:0] HalfMax = CntW'(BitCyc / 2 - 1);

    localparam logic [1:0] RxIdle  = 2'd0;
    localparam logic [1:0] RxStart = 2'd1;
    localparam logic [1:0] RxData  = 2'd2;
    localparam logic [1:0] RxStop  = 2'd3;

    logic            s1_q, line_q, prev_q;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bits_q, bits_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !line_q) state_d = RxStart;
            end
            RxStart: begin
                if (cnt_q == HalfMax) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    state_d = line_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    shreg_d = {line_q, shreg_q[7:1]};
                    bits_d  = bits_q + 1'b1;
                    if (bits_q == 3'd7) state_d = RxStop;
                end
            end
            default: begin
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = !line_q;
                    state_d = RxIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            line_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= rx_i;
            line_q  <= s1_q;
            prev_q  <= line_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign line_o = line_q;
    assign byte_o = shreg_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: rtl/modbus_rtu_slave_rx.sv
// Modbus RTU slave receive front-end: silence framing, CRC check, 0x03/0x10 decode.
module modbus_rtu_slave_rx
    import modbus_rtu_slave_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter logic [7:0]  SLAVE_ADDR = 8'h01,
    parameter int unsigned TIMER_OUT  = 10000,
    parameter int unsigned MAX_FRAME  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_wire,
    output logic [15:0] mb_reg,
    output logic [15:0] mb_num,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        rd_en,
    output logic        crc_err
);
    localparam int unsigned IdxW = $clog2(MAX_FRAME);
    localparam int unsigned LenW = $clog2(MAX_FRAME + 2);
    localparam int unsigned CntW = $clog2(TIMER_OUT);
    localparam logic [CntW-1:0] IdleMax = CntW'(TIMER_OUT - 1);
    localparam logic [LenW-1:0] LenMax  = LenW'(MAX_FRAME + 1);

    logic       byte_done, byte_err, rx_line, good_byte;
    logic [7:0] rx_byte;

    modbus_rtu_slave_rx_uart_byte_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .rx_i  (uart_rx_wire),
        .line_o(rx_line),
        .byte_o(rx_byte),
        .done_o(byte_done),
        .err_o (byte_err)
    );

    logic [7:0]      frame_q [MAX_FRAME];
    logic [2:0]      state_q, state_d;
    logic [LenW-1:0] len_q, len_d;
    logic [15:0]     crc_q, crc_d;
    logic            bad_q, bad_d;
    logic [CntW-1:0] idle_q, idle_d;
    logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]      rem_q, rem_d;
    logic [15:0]     mb_reg_q, mb_reg_d, mb_num_q, mb_num_d;
    logic            wr_en_q, wr_en_d, rd_en_q, rd_en_d, crc_err_q, crc_err_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [15:0]     f_reg, f_num;
    logic            len_ok, wr_ok, rd_ok;

    assign good_byte = byte_done && !byte_err;
    assign f_reg     = {frame_q[2], frame_q[3]};
    assign f_num     = {frame_q[4], frame_q[5]};
    assign len_ok    = !bad_q && len_q >= LenW'(4) && len_q <= LenW'(MAX_FRAME);
    assign wr_ok     = frame_q[1] == FC_WRITE_MULTI
                       && (frame_q[0] == SLAVE_ADDR || frame_q[0] == 8'h00)
                       && {9'd0, frame_q[6]} == {f_num, 1'b0}
                       && 16'(len_q) == 16'd9 + {8'd0, frame_q[6]};
    assign rd_ok     = frame_q[1] == FC_READ_HOLD && frame_q[0] == SLAVE_ADDR
                       && len_q == LenW'(8);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        crc_d     = crc_q;
        bad_d     = bad_q;
        rd_ptr_d  = rd_ptr_q;
        rem_d     = rem_q;
        mb_reg_d  = mb_reg_q;
        mb_num_d  = mb_num_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        rd_en_d   = rd_en_q;
        crc_err_d = crc_err_q;

        if (byte_done || !rx_line) idle_d = '0;
        else if (idle_q == IdleMax) idle_d = idle_q;
        else idle_d = idle_q + 1'b1;

        if (good_byte) begin
            crc_d = crc16_update(crc_q, rx_byte);
            if (len_q != LenMax) len_d = len_q + 1'b1;
        end
        if (byte_done && byte_err) bad_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (byte_done || len_q != '0 || bad_q) state_d = StRecv;
            end
            StRecv: begin
                // A frame made only of framing-error bytes has nothing to check.
                if (idle_d == IdleMax) begin
                    if (len_q != '0) begin
                        state_d = StCheck;
                    end else begin
                        bad_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StCheck: begin
                state_d = StIdle;
                len_d   = '0;
                crc_d   = CRC_INIT;
                bad_d   = 1'b0;
                if (len_ok) begin
                    if (crc_q != 16'h0000) begin
                        crc_err_d = 1'b1;
                        state_d   = StPulse;
                    end else if (wr_ok) begin
                        mb_reg_d = f_reg;
                        mb_num_d = f_num;
                        if (frame_q[6] != 8'h00) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = frame_q[7];
                            rd_ptr_d  = IdxW'(8);
                            rem_d     = frame_q[6] - 8'd1;
                            state_d   = StWrite;
                        end
                    end else if (rd_ok) begin
                        mb_reg_d = f_reg;
                        mb_num_d = f_num;
                        rd_en_d  = 1'b1;
                        state_d  = StPulse;
                    end
                end
            end
            StWrite: begin
                if (rem_q == 8'd0) begin
                    wr_en_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    wr_data_d = frame_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    rem_d     = rem_q - 8'd1;
                end
            end
            StPulse: begin
                rd_en_d   = 1'b0;
                crc_err_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (good_byte && len_q < LenW'(MAX_FRAME)) frame_q[len_q[IdxW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            crc_q     <= CRC_INIT;
            bad_q     <= 1'b0;
            idle_q    <= '0;
            rd_ptr_q  <= '0;
            rem_q     <= '0;
            mb_reg_q  <= '0;
            mb_num_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            bad_q     <= bad_d;
            idle_q    <= idle_d;
            rd_ptr_q  <= rd_ptr_d;
            rem_q     <= rem_d;
            mb_reg_q  <= mb_reg_d;
            mb_num_q  <= mb_num_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign mb_reg  = mb_reg_q;
    assign mb_num  = mb_num_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign crc_err = crc_err_q;

endmodule

// File: tb/tb_modbus_rtu_slave_rx.sv
// Directed frame vectors and corner-case sequences for the Modbus RTU receive front-end.
module tb_modbus_rtu_slave_rx;
    localparam int unsigned ClkFreq  = 1_600_000;
    localparam int unsigned Baud     = 100_000;
    localparam int unsigned BitCyc   = ClkFreq / Baud;
    localparam int unsigned TimerOut = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] mb_reg, mb_num;
    logic        wr_en, rd_en, crc_err;
    logic [7:0]  wr_data;

    always #5 clk = ~clk;

    modbus_rtu_slave_rx #(
        .CLK_FREQ  (ClkFreq),
        .BAUD      (Baud),
        .SLAVE_ADDR(8'h01),
        .TIMER_OUT (TimerOut),
        .MAX_FRAME (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_wire(rx),
        .mb_reg      (mb_reg),
        .mb_num      (mb_num),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .crc_err     (crc_err)
    );

    typedef struct {
        logic [127:0] hex;
        int           n;
        bit           add_crc;
        bit           flip;
        int           exp_wr;
        logic [31:0]  exp_data;
        int           exp_rd;
        int           exp_ce;
        logic [15:0]  exp_reg;
        logic [15:0]  exp_num;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] fb [0:127];
    int         fn;
    int         total = 0;
    int         bad   = 0;

    // Output monitor: running totals sampled on the falling edge.
    logic [7:0] cap [0:255];
    int         wr_tot = 0, wr_bursts = 0, rd_tot = 0, ce_tot = 0;
    logic       wr_prev = 1'b0;
    int         s_wr, s_bursts, s_rd, s_ce;

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_tot < 256) cap[wr_tot] = wr_data;
            wr_tot = wr_tot + 1;
            if (!wr_prev) wr_bursts = wr_bursts + 1;
        end
        if (rd_en) rd_tot = rd_tot + 1;
        if (crc_err) ce_tot = ce_tot + 1;
        wr_prev = wr_en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int start, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = start; i < start + n; i++) begin
            c = c ^ {8'h00, fb[i]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic load_hex(input logic [127:0] h, input int n, input int at);
        for (int i = 0; i < n; i++) fb[at + i] = h[8 * (n - 1 - i) +: 8];
        fn = at + n;
    endtask

    task automatic append_crc(input int start);
        logic [15:0] c;
        c = crc_model(start, fn - start);
        fb[fn]     = c[7:0];
        fb[fn + 1] = c[15:8];
        fn = fn + 2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BitCyc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BitCyc) @(negedge clk);
        end
        rx = stop;
        repeat (BitCyc) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * BitCyc) @(negedge clk);
    endtask

    task automatic send_range(input int from, input int to, input int bad_idx);
        for (int i = from; i < to; i++) send_byte(fb[i], i != bad_idx);
    endtask

    task automatic snap();
        s_wr     = wr_tot;
        s_bursts = wr_bursts;
        s_rd     = rd_tot;
        s_ce     = ce_tot;
    endtask

    task automatic settle();
        repeat (TimerOut + 100) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int e_wr, input logic [31:0] e_data,
                             input int e_rd, input int e_ce, input logic [15:0] e_reg,
                             input logic [15:0] e_num);
        chk({tag, ".wr_cycles"}, 32'(wr_tot - s_wr), 32'(e_wr));
        chk({tag, ".wr_bursts"}, 32'(wr_bursts - s_bursts), (e_wr > 0) ? 32'd1 : 32'd0);
        for (int j = 0; j < e_wr; j++) begin
            chk($sformatf("%s.wr_data%0d", tag, j), {24'd0, cap[s_wr + j]},
                {24'd0, e_data[8 * (e_wr - 1 - j) +: 8]});
        end
        chk({tag, ".rd_cycles"}, 32'(rd_tot - s_rd), 32'(e_rd));
        chk({tag, ".crc_err_cycles"}, 32'(ce_tot - s_ce), 32'(e_ce));
        chk({tag, ".mb_reg"}, {16'd0, mb_reg}, {16'd0, e_reg});
        chk({tag, ".mb_num"}, {16'd0, mb_num}, {16'd0, e_num});
    endtask

    initial begin
        logic [15:0] mc;
        vecs[0] = '{hex: 128'h01_10_00_00_00_02_04_41_30_00_00, n: 11, add_crc: 1, flip: 0,
                    exp_wr: 4, exp_data: 32'h41300000, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0000, exp_num: 16'h0002};
        vecs[1] = '{hex: 128'h01_03_00_10_00_03, n: 6, add_crc: 1, flip: 0,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 1, exp_ce: 0,
                    exp_reg: 16'h0010, exp_num: 16'h0003};
        vecs[2] = '{hex: 128'h01_10_00_00_00_02_04_41_30_00_00, n: 11, add_crc: 1, flip: 1,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 0, exp_ce: 1,
                    exp_reg: 16'h0010, exp_num: 16'h0003};
        vecs[3] = '{hex: 128'h05_10_00_00_00_02_04_41_30_00_00, n: 11, add_crc: 1, flip: 0,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0010, exp_num: 16'h0003};
        vecs[4] = '{hex: 128'h00_10_00_20_00_01_02_AB_CD, n: 9, add_crc: 1, flip: 0,
                    exp_wr: 2, exp_data: 32'h0000ABCD, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0020, exp_num: 16'h0001};
        vecs[5] = '{hex: 128'h00_03_00_10_00_03, n: 6, add_crc: 1, flip: 0,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0020, exp_num: 16'h0001};
        vecs[6] = '{hex: 128'h01_10_00_05_00_02_02_11_22, n: 9, add_crc: 1, flip: 0,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0020, exp_num: 16'h0001};
        vecs[7] = '{hex: 128'h01_06_00_01_00_03, n: 6, add_crc: 1, flip: 0,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0020, exp_num: 16'h0001};
        vecs[8] = '{hex: 128'h01_03, n: 2, add_crc: 0, flip: 0,
                    exp_wr: 0, exp_data: 32'h0, exp_rd: 0, exp_ce: 0,
                    exp_reg: 16'h0020, exp_num: 16'h0001};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.mb_reg", {16'd0, mb_reg}, 32'd0);
        chk("reset.mb_num", {16'd0, mb_num}, 32'd0);
        chk("reset.strobes", {29'd0, wr_en, rd_en, crc_err}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            load_hex(vecs[v].hex, vecs[v].n, 0);
            if (vecs[v].add_crc) append_crc(0);
            if (vecs[v].flip) fb[fn - 1] = fb[fn - 1] ^ 8'hFF;
            snap();
            send_range(0, fn, -1);
            settle();
            check_out($sformatf("vec%0d", v), vecs[v].exp_wr, vecs[v].exp_data, vecs[v].exp_rd,
                      vecs[v].exp_ce, vecs[v].exp_reg, vecs[v].exp_num);
        end

        // Two valid read frames back to back merge into one 16-byte frame.
        load_hex(128'h01_03_00_10_00_03, 6, 0);
        append_crc(0);
        load_hex(128'h01_03_00_20_00_04, 6, 8);
        append_crc(8);
        mc = crc_model(0, 16);
        snap();
        send_range(0, fn, -1);
        settle();
        check_out("merged", 0, 32'h0, 0, (mc != 16'h0000) ? 1 : 0, 16'h0020, 16'h0001);

        // Same pair of frames, but separated by a full idle timeout.
        load_hex(128'h01_03_00_10_00_03, 6, 0);
        append_crc(0);
        load_hex(128'h01_10_00_30_00_01_02_12_34, 9, 8);
        append_crc(8);
        snap();
        send_range(0, 8, -1);
        repeat (TimerOut + 50) @(negedge clk);
        chk("gap.first_rd", {16'd0, mb_reg}, 32'h0010);
        send_range(8, fn, -1);
        settle();
        check_out("gap", 2, 32'h00001234, 1, 0, 16'h0030, 16'h0001);

        // Framing error on byte 3 poisons the whole frame.
        load_hex(vecs[0].hex, 11, 0);
        append_crc(0);
        snap();
        send_range(0, fn, 3);
        settle();
        check_out("stopbit", 0, 32'h0, 0, 0, 16'h0030, 16'h0001);

        // 70 bytes overflow the 64-byte buffer.
        for (int i = 0; i < 70; i++) fb[i] = 8'h55;
        fn = 70;
        snap();
        send_range(0, fn, -1);
        settle();
        check_out("overflow", 0, 32'h0, 0, 0, 16'h0030, 16'h0001);

        // Reset in the middle of a frame discards it and clears the outputs.
        load_hex(vecs[0].hex, 11, 0);
        append_crc(0);
        snap();
        send_range(0, 5, -1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();
        check_out("midreset", 0, 32'h0, 0, 0, 16'h0000, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
